// File: rtl/riscv_define_all.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding, forwarding-select codes and the in-flight slot record.
package riscv_define_all;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StStall  = 2'd1,
        StFreeze = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    // One in-flight instruction tracked after ID.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    localparam int unsigned SLOT_W = $bits(slot_t);

    // A slot only produces a value others can depend on if it really writes a non-x0 register.
    function automatic logic slot_writing(slot_t s);
        return s.valid && s.we && (s.rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: compares one ID source register against the ex/mem/wb slots and
// reports whether it must stall and which operand source to use.
// Optional feature macro: HAZARD_FORWARDING_EN (forward from EX/MEM and MEM/WB
// instead of stalling; only load-use and non-bypassed WB matches stall).
module hazard_cmp
    import riscv_define_all::*;
#(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic       i_re,
    input  logic [4:0] i_addr,
    input  slot_t      i_ex,
    input  slot_t      i_mem,
    input  slot_t      i_wb,
    output logic       o_conflict,
    output logic [1:0] o_fwd_sel
);

    logic w_src;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_wb_conflict;
    logic w_unused;

    // x0 reads and disabled reads never depend on anything.
    assign w_src     = i_re && (i_addr != 5'd0);
    assign w_ex_hit  = w_src && slot_writing(i_ex)  && (i_ex.rd  == i_addr);
    assign w_mem_hit = w_src && slot_writing(i_mem) && (i_mem.rd == i_addr);
    assign w_wb_hit  = w_src && slot_writing(i_wb)  && (i_wb.rd  == i_addr);

    // A WB producer is harmless when the regfile writes before it is read.
    assign w_wb_conflict = w_wb_hit && !WB_BYPASS;

    assign w_unused = ^{i_ex.is_load, i_mem.is_load, i_wb.is_load, FWD_EXMEM, FWD_MEMWB};

    // Youngest matching producer decides between stall and forwarding source.
    always_comb begin
        o_conflict = 1'b0;
        o_fwd_sel  = FWD_REGFILE;
`ifdef HAZARD_FORWARDING_EN
        if (w_ex_hit) begin
            // Load data is not in EX/MEM yet: one bubble, then it comes from MEM/WB.
            if (i_ex.is_load) begin
                o_conflict = 1'b1;
            end else begin
                o_fwd_sel = FWD_EXMEM;
            end
        end else if (w_mem_hit) begin
            o_fwd_sel = FWD_MEMWB;
        end else begin
            o_conflict = w_wb_conflict;
        end
`else
        o_conflict = w_ex_hit || w_mem_hit || w_wb_conflict;
`endif
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, stall/flush/bubble/freeze sequencing and a
// saturating stall-cycle counter for the 5-stage core.
// Optional feature macro: HAZARD_FORWARDING_EN (operand forwarding selects;
// without it fwd_sel_1/fwd_sel_2 stay 0 and every RAW match stalls).
module hazard_ctrl
    import riscv_define_all::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter bit          WB_BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_r1_re,
    input  logic [4:0]       id_r1_addr,
    input  logic             id_r2_re,
    input  logic [4:0]       id_r2_addr,
    input  logic             id_rd_we,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_is_load,
    input  logic             id_br,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic [1:0]       fwd_sel_1,
    output logic [1:0]       fwd_sel_2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       ctrl_state
);

    localparam slot_t SlotBubble = slot_t'({SLOT_W{1'b0}});

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    slot_t            w_id_slot;
    ctrl_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_conf_1;
    logic             w_conf_2;
    logic             w_hazard;
    logic             w_accept;

    hazard_cmp #(
        .WB_BYPASS (WB_BYPASS)
    ) u_cmp_1 (
        .i_re       (id_r1_re),
        .i_addr     (id_r1_addr),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_conflict (w_conf_1),
        .o_fwd_sel  (fwd_sel_1)
    );

    hazard_cmp #(
        .WB_BYPASS (WB_BYPASS)
    ) u_cmp_2 (
        .i_re       (id_r2_re),
        .i_addr     (id_r2_addr),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_conflict (w_conf_2),
        .o_fwd_sel  (fwd_sel_2)
    );

    assign w_hazard = id_valid && (w_conf_1 || w_conf_2);
    assign w_accept = id_valid && !w_hazard && !mem_busy;

    // Record of the ID instruction as it would enter the ex slot.
    always_comb begin
        w_id_slot         = SlotBubble;
        w_id_slot.valid   = 1'b1;
        w_id_slot.we      = id_rd_we;
        w_id_slot.rd      = id_rd_addr;
        w_id_slot.is_load = id_is_load;
    end

    // Stage-control decode: mem_busy beats hazard, hazard beats branch; all low in reset.
    always_comb begin
        pc_stall    = reset && (mem_busy || w_hazard);
        ifid_stall  = reset && (mem_busy || w_hazard);
        idex_bubble = reset && w_hazard && !mem_busy;
        ifid_flush  = reset && id_br && id_valid && !w_hazard && !mem_busy;
        freeze      = reset && mem_busy;
    end

    // In-flight slots shift every cycle except while the memory freezes the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex  <= SlotBubble;
            r_mem <= SlotBubble;
            r_wb  <= SlotBubble;
        end else if (!mem_busy) begin
            r_ex  <= w_accept ? w_id_slot : SlotBubble;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // Control FSM plus saturating count of hazard-stall cycles (freeze cycles excluded).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            if (w_hazard && !mem_busy && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            unique case (r_state)
                StRun: begin
                    if (mem_busy) begin
                        r_state <= StFreeze;
                    end else if (w_hazard) begin
                        r_state <= StStall;
                    end
                end
                StStall: begin
                    if (mem_busy) begin
                        r_state <= StFreeze;
                    end else if (!w_hazard) begin
                        r_state <= StRun;
                    end
                end
                StFreeze: begin
                    if (!mem_busy) begin
                        r_state <= w_hazard ? StStall : StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    assign stall_cnt  = r_cnt;
    assign ctrl_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver predicts each cycle's outputs from
// a list of in-flight producers aged by cycles since issue; the monitor compares.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam bit          WB_BYP  = 1'b0;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam int RAW_STALLS = 0;
`else
    localparam int RAW_STALLS = WB_BYP ? 2 : 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic             id_r1_re;
    logic [4:0]       id_r1_addr;
    logic             id_r2_re;
    logic [4:0]       id_r2_addr;
    logic             id_rd_we;
    logic [4:0]       id_rd_addr;
    logic             id_is_load;
    logic             id_br;
    logic             mem_busy;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             freeze;
    logic [1:0]       fwd_sel_1;
    logic [1:0]       fwd_sel_2;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       ctrl_state;

    hazard_ctrl #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (WB_BYP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_r1_re    (id_r1_re),
        .id_r1_addr  (id_r1_addr),
        .id_r2_re    (id_r2_re),
        .id_r2_addr  (id_r2_addr),
        .id_rd_we    (id_rd_we),
        .id_rd_addr  (id_rd_addr),
        .id_is_load  (id_is_load),
        .id_br       (id_br),
        .mem_busy    (mem_busy),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .freeze      (freeze),
        .fwd_sel_1   (fwd_sel_1),
        .fwd_sel_2   (fwd_sel_2),
        .stall_cnt   (stall_cnt),
        .ctrl_state  (ctrl_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pcs;
        logic             ifs;
        logic             flush;
        logic             bub;
        logic             frz;
        logic [1:0]       f1;
        logic [1:0]       f2;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       st;
    } exp_t;

    // Issued producer: age 1 = one cycle past ID (EX), 2 = MEM, 3 = WB.
    typedef struct packed {
        int unsigned age;
        logic        we;
        logic [4:0]  rd;
        logic        ld;
    } fl_t;

    exp_t        exp_q[$];
    fl_t         fl[$];
    int unsigned m_cnt;
    int          m_state;
    bit          last_haz;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Dependency of one source on the youngest in-flight writer of that register.
    function automatic void src_eval(input logic re, input logic [4:0] addr,
                                     output bit conf, output logic [1:0] fwd);
        int   best;
        logic best_ld;
        best    = 0;
        best_ld = 1'b0;
        conf    = 1'b0;
        fwd     = 2'd0;
        if (!re || addr == 5'd0) return;
        foreach (fl[i]) begin
            if (fl[i].we && fl[i].rd == addr && (best == 0 || int'(fl[i].age) < best)) begin
                best    = int'(fl[i].age);
                best_ld = fl[i].ld;
            end
        end
        if (best == 0) return;
`ifdef HAZARD_FORWARDING_EN
        if (best == 1) begin
            if (best_ld) conf = 1'b1;
            else fwd = 2'd1;
        end else if (best == 2) begin
            fwd = 2'd2;
        end else begin
            conf = !WB_BYP;
        end
`else
        conf = (best <= (WB_BYP ? 2 : 3));
`endif
    endfunction

    task automatic model_reset();
        fl.delete();
        m_cnt    = 0;
        m_state  = 0;
        last_haz = 1'b0;
    endtask

    // One cycle of ID inputs; predicts this cycle's outputs and advances the model.
    task automatic drive(input int v, input int r1e, input int r1, input int r2e, input int r2,
                         input int we, input int rd, input int ld, input int br, input int busy);
        bit         c1;
        bit         c2;
        bit         haz;
        logic [1:0] f1;
        logic [1:0] f2;
        exp_t       e;
        fl_t        nq[$];
        fl_t        t;
        @(posedge clk);
        #2;
        id_valid   = v[0];
        id_r1_re   = r1e[0];
        id_r1_addr = r1[4:0];
        id_r2_re   = r2e[0];
        id_r2_addr = r2[4:0];
        id_rd_we   = we[0];
        id_rd_addr = rd[4:0];
        id_is_load = ld[0];
        id_br      = br[0];
        mem_busy   = busy[0];
        src_eval(r1e[0], r1[4:0], c1, f1);
        src_eval(r2e[0], r2[4:0], c2, f2);
        haz     = v[0] && (c1 || c2);
        e.pcs   = busy[0] || haz;
        e.ifs   = busy[0] || haz;
        e.bub   = haz && !busy[0];
        e.flush = br[0] && v[0] && !haz && !busy[0];
        e.frz   = busy[0];
        e.f1    = f1;
        e.f2    = f2;
        e.cnt   = CNT_W'(m_cnt);
        e.st    = 2'(m_state);
        exp_q.push_back(e);
        if (haz && !busy[0] && m_cnt < CNT_MAX) m_cnt++;
        m_state = busy[0] ? 2 : (haz ? 1 : 0);
        if (!busy[0]) begin
            foreach (fl[i]) begin
                if (fl[i].age < 3) begin
                    t = fl[i];
                    t.age++;
                    nq.push_back(t);
                end
            end
            if (v[0] && !haz) begin
                t.age = 1;
                t.we  = we[0];
                t.rd  = rd[4:0];
                t.ld  = ld[0];
                nq.push_back(t);
            end
            fl = nq;
        end
        last_haz = haz;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every predicted cycle away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_stall",    int'(pc_stall),    int'(e.pcs));
                chk("ifid_stall",  int'(ifid_stall),  int'(e.ifs));
                chk("ifid_flush",  int'(ifid_flush),  int'(e.flush));
                chk("idex_bubble", int'(idex_bubble), int'(e.bub));
                chk("freeze",      int'(freeze),      int'(e.frz));
                chk("fwd_sel_1",   int'(fwd_sel_1),   int'(e.f1));
                chk("fwd_sel_2",   int'(fwd_sel_2),   int'(e.f2));
                chk("stall_cnt",   int'(stall_cnt),   int'(e.cnt));
                chk("ctrl_state",  int'(ctrl_state),  int'(e.st));
            end
        end
    end

    initial begin
        int n;
        reset      = 1'b0;
        id_valid   = 1'b0;
        id_r1_re   = 1'b0;
        id_r1_addr = 5'd0;
        id_r2_re   = 1'b0;
        id_r2_addr = 5'd0;
        id_rd_we   = 1'b0;
        id_rd_addr = 5'd0;
        id_is_load = 1'b0;
        id_br      = 1'b0;
        mem_busy   = 1'b0;
        model_reset();
        #3;
        chk("rst_pc_stall",   int'(pc_stall),    0);
        chk("rst_bubble",     int'(idex_bubble), 0);
        chk("rst_flush",      int'(ifid_flush),  0);
        chk("rst_freeze",     int'(freeze),      0);
        chk("rst_state",      int'(ctrl_state),  0);
        chk("rst_stall_cnt",  int'(stall_cnt),   0);
        chk("rst_fwd_sel_1",  int'(fwd_sel_1),   0);
        #9;
        reset = 1'b1;

        // ADDI x5,x1 then ADD x6,x5,x1 held in ID until accepted
        drive(1, 1, 1, 0, 0, 1, 5, 0, 0, 0);
        n = 0;
        do begin
            drive(1, 1, 5, 1, 1, 1, 6, 0, 0, 0);
            n++;
        end while (last_haz && n < 8);
        #1;
        chk("raw_stall_cnt", int'(stall_cnt), RAW_STALLS);
        chk("raw_accept_no_bubble", int'(idex_bubble), 0);
        nops(3);

        // LW x7 then ADD x8,x7,x7 (load-use)
        drive(1, 1, 2, 0, 0, 1, 7, 1, 0, 0);
        n = 0;
        do begin
            drive(1, 1, 7, 1, 7, 1, 8, 0, 0, 0);
            n++;
        end while (last_haz && n < 8);
        nops(4);

        // Taken branch with no dependency: one-cycle flush
        drive(1, 1, 1, 1, 2, 0, 0, 0, 1, 0);
        #1;
        chk("beq_flush", int'(ifid_flush), 1);
        chk("beq_pc_stall", int'(pc_stall), 0);
        drive(1, 1, 3, 0, 0, 1, 9, 0, 0, 0);
        #1;
        chk("beq_flush_once", int'(ifid_flush), 0);
        nops(3);

        // Hazard stall interrupted by a 4-cycle memory freeze
        drive(1, 1, 1, 0, 0, 1, 5, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 1);
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 1);
        #1;
        chk("frz_state", int'(ctrl_state), 2);
        chk("frz_flag", int'(freeze), 1);
        chk("frz_no_bubble", int'(idex_bubble), 0);
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 1);
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 1);
        n = 0;
        do begin
            drive(1, 1, 5, 0, 0, 1, 6, 0, 0, 0);
            n++;
        end while (last_haz && n < 8);
        nops(3);

        // Asynchronous reset in the middle of a stall
        drive(1, 1, 1, 0, 0, 1, 9, 0, 0, 0);
        drive(1, 1, 9, 0, 0, 1, 10, 0, 0, 0);
        drive(1, 1, 9, 0, 0, 1, 10, 0, 0, 0);
        @(negedge clk);
        #2;
        id_br    = 1'b1;
        mem_busy = 1'b1;
        reset    = 1'b0;
        #1;
        chk("arst_pc_stall",  int'(pc_stall),    0);
        chk("arst_ifid_stall", int'(ifid_stall), 0);
        chk("arst_bubble",    int'(idex_bubble), 0);
        chk("arst_flush",     int'(ifid_flush),  0);
        chk("arst_freeze",    int'(freeze),      0);
        chk("arst_state",     int'(ctrl_state),  0);
        chk("arst_stall_cnt", int'(stall_cnt),   0);
        chk("arst_fwd_sel_1", int'(fwd_sel_1),   0);
        model_reset();
        id_br    = 1'b0;
        mem_busy = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;

        // Writer of x0 followed by readers of x0: never a hazard
        drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 1, 11, 0, 0, 0);
        #1;
        chk("x0_no_stall", int'(pc_stall), 0);
        nops(2);

        // Random traffic over a few registers so dependencies are frequent
        for (int i = 0; i < 3000; i++) begin
            drive(int'($urandom_range(0, 9) != 0),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
